// File: rtl/rotor_stepper_if.sv
// Keypress / rotor-offset bus between the keyboard front end and the rotor stepper.
interface rotor_stepper_if;
  logic       key_valid;
  logic [4:0] letter_in;
  logic       load;
  logic [4:0] load_pos1;
  logic [4:0] load_pos2;
  logic [4:0] load_pos3;
  logic       ready;
  logic [4:0] letter_q;
  logic [4:0] rotate1;
  logic [4:0] rotate2;
  logic [4:0] rotate3;
  logic       out_valid;

  // Keyboard / controller side: issues keys and start positions.
  modport master (
    output key_valid, letter_in, load, load_pos1, load_pos2, load_pos3,
    input  ready, letter_q, rotate1, rotate2, rotate3, out_valid
  );

  // Stepper side: accepts keys, presents letter and offsets.
  modport slave (
    input  key_valid, letter_in, load, load_pos1, load_pos2, load_pos3,
    output ready, letter_q, rotate1, rotate2, rotate3, out_valid
  );
endinterface

// File: rtl/rotor_stepper.sv
// Rotor chain front end: latches a keyed letter, steps the three rotor
// offsets with the Enigma double-step, holds them for a settle window and
// then pulses out_valid for the lamp/display stage.
module rotor_stepper #(
  parameter logic [4:0]  NOTCH1        = 5'd16,
  parameter logic [4:0]  NOTCH2        = 5'd4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic           clk,
  input logic           rst,
  rotor_stepper_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);
  localparam logic [4:0] LAST_POS    = 5'd25;
  localparam logic [4:0] LAST_LETTER = 5'd26;

  state_t     state, state_next;
  logic [4:0] letter_r, letter_next;
  logic [4:0] rot1_r, rot1_next;
  logic [4:0] rot2_r, rot2_next;
  logic [4:0] rot3_r, rot3_next;
  logic [3:0] cnt_r, cnt_next;

  logic       key_ok;
  logic       step2;
  logic       step3;

  // Offsets only ever hold 0..25, so 25 is the sole wrap point.
  function automatic logic [4:0] inc26(input logic [4:0] v);
    return (v >= LAST_POS) ? 5'd0 : v + 5'd1;
  endfunction

  // Out-of-range start positions collapse to 0 for that rotor only.
  function automatic logic [4:0] clamp_pos(input logic [4:0] v);
    return (v > LAST_POS) ? 5'd0 : v;
  endfunction

  // Key validity and stepping decisions, all on pre-step offsets.
  always_comb begin
    key_ok = bus.key_valid && (bus.letter_in != 5'd0) && (bus.letter_in <= LAST_LETTER);
    step3  = (rot2_r == NOTCH2);
    step2  = (rot1_r == NOTCH1) || step3;
  end

  // State register and registered datapath outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      letter_r <= '0;
      rot1_r   <= '0;
      rot2_r   <= '0;
      rot3_r   <= '0;
      cnt_r    <= '0;
    end else begin
      state    <= state_next;
      letter_r <= letter_next;
      rot1_r   <= rot1_next;
      rot2_r   <= rot2_next;
      rot3_r   <= rot3_next;
      cnt_r    <= cnt_next;
    end
  end

  // Next-state and next-datapath logic; load has priority over a key in IDLE.
  always_comb begin
    state_next  = state;
    letter_next = letter_r;
    rot1_next   = rot1_r;
    rot2_next   = rot2_r;
    rot3_next   = rot3_r;
    cnt_next    = cnt_r;
    unique case (state)
      IDLE: begin
        if (bus.load) begin
          rot1_next = clamp_pos(bus.load_pos1);
          rot2_next = clamp_pos(bus.load_pos2);
          rot3_next = clamp_pos(bus.load_pos3);
        end else if (key_ok) begin
          letter_next = bus.letter_in;
          rot1_next   = inc26(rot1_r);
          rot2_next   = step2 ? inc26(rot2_r) : rot2_r;
          rot3_next   = step3 ? inc26(rot3_r) : rot3_r;
          cnt_next    = SETTLE_INIT;
          state_next  = SETTLE;
        end
      end
      SETTLE: begin
        cnt_next = cnt_r - 4'd1;
        if (cnt_r <= 4'd1) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake outputs decode directly from the state.
  always_comb begin
    bus.ready     = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.letter_q  = letter_r;
    bus.rotate1   = rot1_r;
    bus.rotate2   = rot2_r;
    bus.rotate3   = rot3_r;
  end

endmodule

// File: tb/tb_rotor_stepper.sv
// Scoreboard bench for rotor_stepper: directed keypresses and loads with
// hand-computed offsets; a monitor checks every out_valid pulse.
module tb_rotor_stepper;

  localparam int SETTLE = 2;

  typedef struct {
    int letter;
    int r1;
    int r2;
    int r3;
    int due;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_tests;
  int   n_fail;
  exp_t sb[$];

  rotor_stepper_if bus();

  rotor_stepper #(
    .NOTCH1       (5'd16),
    .NOTCH2       (5'd4),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest outstanding key.
  always @(negedge clk) begin
    if (bus.out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_letter", int'(bus.letter_q), e.letter);
        check("out_rotate1", int'(bus.rotate1), e.r1);
        check("out_rotate2", int'(bus.rotate2), e.r2);
        check("out_rotate3", int'(bus.rotate3), e.r3);
        check("out_latency", cyc, e.due);
        check("out_ready_low", int'(bus.ready), 0);
      end
    end
  end

  task automatic check_state(input string tag, input int el, input int e1, input int e2,
                             input int e3, input int erdy);
    check({tag, "_letter"}, int'(bus.letter_q), el);
    check({tag, "_rotate1"}, int'(bus.rotate1), e1);
    check({tag, "_rotate2"}, int'(bus.rotate2), e2);
    check({tag, "_rotate3"}, int'(bus.rotate3), e3);
    check({tag, "_ready"}, int'(bus.ready), erdy);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_state(tag, 0, 0, 0, 0, 1);
    check({tag, "_out_valid"}, int'(bus.out_valid), 0);
  endtask

  // One keypress; el/e1..e3 are the expected letter_q/offsets after the edge.
  task automatic press(input string tag, input logic [4:0] letter, input bit accept,
                       input int el, input int e1, input int e2, input int e3, input bit push);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.letter_in = letter;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    bus.letter_in = '0;
    check_state(tag, el, e1, e2, e3, accept ? 0 : 1);
    if (accept && push) begin
      sb.push_back('{letter: el, r1: e1, r2: e2, r3: e3, due: cyc + SETTLE});
    end
  endtask

  task automatic do_load(input string tag, input logic [4:0] p1, input logic [4:0] p2,
                         input logic [4:0] p3, input bit with_key,
                         input int el, input int e1, input int e2, input int e3);
    @(negedge clk);
    bus.load      = 1'b1;
    bus.load_pos1 = p1;
    bus.load_pos2 = p2;
    bus.load_pos3 = p3;
    bus.key_valid = with_key;
    bus.letter_in = 5'd8;
    @(posedge clk);
    #1;
    bus.load      = 1'b0;
    bus.key_valid = 1'b0;
    bus.letter_in = '0;
    check_state(tag, el, e1, e2, e3, 1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.ready) break;
    end
    check({tag, "_ready_return"}, int'(bus.ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests + 1, n_fail + 1);
    $fatal(1);
  end

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    cyc           = 0;
    rst           = 1'b1;
    bus.key_valid = 1'b0;
    bus.letter_in = '0;
    bus.load      = 1'b0;
    bus.load_pos1 = '0;
    bus.load_pos2 = '0;
    bus.load_pos3 = '0;
    repeat (3) @(posedge clk);

    do_reset("t1_reset");

    press("t2_key1", 5'd1, 1'b1, 1, 1, 0, 0, 1'b1);
    wait_idle("t2");

    do_load("t3_load", 5'd15, 5'd3, 5'd0, 1'b0, 1, 15, 3, 0);
    press("t3_key_a", 5'd2, 1'b1, 2, 16, 3, 0, 1'b1);
    wait_idle("t3a");
    press("t3_key_b", 5'd3, 1'b1, 3, 17, 4, 0, 1'b1);
    wait_idle("t3b");
    press("t3_double", 5'd4, 1'b1, 4, 18, 5, 1, 1'b1);
    wait_idle("t3c");

    do_load("t4_load", 5'd25, 5'd25, 5'd25, 1'b0, 4, 25, 25, 25);
    press("t4_wrap", 5'd26, 1'b1, 26, 0, 25, 25, 1'b1);
    wait_idle("t4");
    do_load("t4_clamp", 5'd30, 5'd7, 5'd2, 1'b0, 26, 0, 7, 2);

    press("t5_zero", 5'd0, 1'b0, 26, 0, 7, 2, 1'b0);
    press("t5_27", 5'd27, 1'b0, 26, 0, 7, 2, 1'b0);

    // Key and load held across the whole settle window must be ignored.
    press("t5_key5", 5'd5, 1'b1, 5, 1, 7, 2, 1'b1);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.letter_in = 5'd6;
    bus.load      = 1'b1;
    bus.load_pos1 = 5'd9;
    bus.load_pos2 = 5'd9;
    bus.load_pos3 = 5'd9;
    check("t5_settle_ready", int'(bus.ready), 0);
    @(negedge clk);
    check("t5_settle_ready2", int'(bus.ready), 0);
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.load      = 1'b0;
    bus.letter_in = '0;
    check_state("t5_after_settle", 5, 1, 7, 2, 0);
    wait_idle("t5");
    check_state("t5_idle", 5, 1, 7, 2, 1);

    // Reset during SETTLE aborts with no pulse.
    press("t6_key7", 5'd7, 1'b1, 7, 2, 7, 2, 1'b0);
    do_reset("t6_abort");
    repeat (5) @(negedge clk);
    check("t6_no_pulse_ready", int'(bus.ready), 1);

    do_load("t6_load_key", 5'd3, 5'd4, 5'd5, 1'b1, 0, 3, 4, 5);
    @(negedge clk);
    check("t6_still_idle", int'(bus.ready), 1);

    press("t7_notch2", 5'd9, 1'b1, 9, 4, 5, 6, 1'b1);
    wait_idle("t7a");
    do_load("t7_load", 5'd16, 5'd4, 5'd10, 1'b0, 9, 16, 4, 10);
    press("t7_both", 5'd10, 1'b1, 10, 17, 5, 11, 1'b1);
    wait_idle("t7b");
    do_load("t7_load2", 5'd16, 5'd25, 5'd25, 1'b0, 10, 16, 25, 25);
    press("t7_r2wrap", 5'd11, 1'b1, 11, 17, 0, 25, 1'b1);
    wait_idle("t7c");

    repeat (4) @(negedge clk);
    check("queue_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
